// File: rtl/inst_fetch.sv
// Instruction fetch: FSM-driven memory requests into a DEPTH-entry buffer.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt/perf_stall_cnt.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   r_req_addr;
    logic [31:0]   r_buf_pc   [DEPTH];
    logic [31:0]   r_buf_inst [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;

    assign imem_req  = (r_state != S_IDLE);
    // Address is frozen at issue so a redirect cannot disturb a live request
    assign imem_addr = imem_req ? r_req_addr : r_fetch_pc;
    assign out_valid = (r_count != '0);
    assign out_inst  = r_buf_inst[r_rptr];
    assign out_pc    = r_buf_pc[r_rptr];
    assign w_pop     = out_valid && out_ready && !redirect_valid;

    // Next-state, next fetch PC and push decision
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        w_issue        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!redirect_valid && (r_count < FULL)) begin
                    w_state_nxt = S_WAIT;
                    w_issue     = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_state_nxt = imem_ack ? S_IDLE : S_DROP;
                end else if (imem_ack) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (redirect_valid) begin
            w_fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
        end
    end

    // FSM state, fetch PC and latched request address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            if (w_issue) begin
                r_req_addr <= r_fetch_pc;
            end
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Buffer storage; contents are qualified by the count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wptr]   <= r_fetch_pc;
            r_buf_inst[r_wptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    // Fetched-word and decoder-starved cycle counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (out_ready && !out_valid) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
